// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared opcodes and buffer states
// for the decode-stage immediate extender.
package imm_ext_pkg;

    localparam logic [2:0] EXT_ZERO   = 3'b000;
    localparam logic [2:0] EXT_SIGN   = 3'b001;
    localparam logic [2:0] EXT_UPPER  = 3'b010;
    localparam logic [2:0] EXT_BRANCH = 3'b011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/imm_ext_if.sv
// imm_ext_if: valid/ready bundle between the
// immediate producer, the extender and its consumer.
interface imm_ext_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  immediate;
    logic [2:0]        ext_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              out_err;

    modport master (
        output in_valid, immediate, ext_op, out_ready,
        input  in_ready, out_valid, result, out_err
    );

    modport slave (
        input  in_valid, immediate, ext_op, out_ready,
        output in_ready, out_valid, result, out_err
    );
endinterface

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension;
// undefined opcodes give zero with err set.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [IMM_W-1:0]  immediate,
    input  logic [2:0]        ext_op,
    output logic [DATA_W-1:0] result,
    output logic              err
);
    localparam int N = DATA_W - IMM_W;

    logic [DATA_W-1:0] sext;

    assign sext = {{N{immediate[IMM_W-1]}}, immediate};

    always_comb begin
        result = '0;
        err    = 1'b0;
        unique case (ext_op)
            EXT_ZERO:   result = {{N{1'b0}}, immediate};
            EXT_SIGN:   result = sext;
            EXT_UPPER:  result = {immediate, {N{1'b0}}};
            EXT_BRANCH: result = {sext[DATA_W-3:0], 2'b00};
            default:    err    = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender with
// a two-entry skid buffer and redirect flush.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    imm_ext_if.slave  io
);
    buf_state_t        state_q, state_d;
    logic [DATA_W-1:0] main_res_q, main_res_d;
    logic              main_err_q, main_err_d;
    logic [DATA_W-1:0] skid_res_q, skid_res_d;
    logic              skid_err_q, skid_err_d;
    logic [DATA_W-1:0] ext_res;
    logic              ext_err;
    logic              acc;
    logic              drn;

    imm_ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .immediate (io.immediate),
        .ext_op    (io.ext_op),
        .result    (ext_res),
        .err       (ext_err)
    );

    assign io.in_ready  = (state_q != SKID);
    assign io.out_valid = (state_q != EMPTY);
    assign io.result    = main_res_q;
    assign io.out_err   = main_err_q;

    // a flushed input is never accepted, even with in_ready high
    assign acc = io.in_valid && io.in_ready && !flush;
    assign drn = io.out_valid && io.out_ready;

    always_comb begin
        state_d    = state_q;
        main_res_d = main_res_q;
        main_err_d = main_err_q;
        skid_res_d = skid_res_q;
        skid_err_d = skid_err_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_res_d = ext_res;
                        main_err_d = ext_err;
                        state_d    = FULL;
                    end
                end
                FULL: begin
                    if (acc && drn) begin
                        main_res_d = ext_res;
                        main_err_d = ext_err;
                    end else if (acc) begin
                        skid_res_d = ext_res;
                        skid_err_d = ext_err;
                        state_d    = SKID;
                    end else if (drn) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (drn) begin
                        main_res_d = skid_res_q;
                        main_err_d = skid_err_q;
                        state_d    = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_res_q <= '0;
            main_err_q <= 1'b0;
            skid_res_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_res_q <= main_res_d;
            main_err_q <= main_err_d;
            skid_res_q <= skid_res_d;
            skid_err_q <= skid_err_d;
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed vectors for the 32-bit
// and 64-bit immediate extender pipelines.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    logic clk;
    logic reset;
    logic flush;
    int   n_run;
    int   n_fail;

    imm_ext_if #(.DATA_W(32), .IMM_W(16)) bus ();
    imm_ext_if #(.DATA_W(64), .IMM_W(16)) bus64 ();

    imm_ext_pipe #(.DATA_W(32), .IMM_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .io    (bus.slave)
    );

    imm_ext_pipe #(.DATA_W(64), .IMM_W(16)) u_dut64 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .io    (bus64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] op, input logic [15:0] imm);
        bus.in_valid  = 1'b1;
        bus.ext_op    = op;
        bus.immediate = imm;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        bus.in_valid    = 1'b0;
        bus.immediate   = '0;
        bus.ext_op      = '0;
        bus.out_ready   = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.immediate = '0;
        bus64.ext_op    = '0;
        bus64.out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd1);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_err", 64'(bus.out_err), 64'd0);

        // streaming, one result per cycle
        reset = 1'b0;
        bus.out_ready = 1'b1;
        offer(EXT_ZERO, 16'h8001);
        step();
        check("zero_valid", 64'(bus.out_valid), 64'd1);
        check("zero", 64'(bus.result), 64'h0000_8001);
        offer(EXT_SIGN, 16'h8001);
        step();
        check("sign", 64'(bus.result), 64'hFFFF_8001);
        offer(EXT_UPPER, 16'h1234);
        step();
        check("upper", 64'(bus.result), 64'h1234_0000);
        offer(EXT_BRANCH, 16'hFFFF);
        step();
        check("branch", 64'(bus.result), 64'hFFFF_FFFC);
        check("branch_err", 64'(bus.out_err), 64'd0);
        bus.in_valid = 1'b0;
        step();
        check("drained", 64'(bus.out_valid), 64'd0);

        // undefined opcode then a good one
        offer(3'b101, 16'h7FFF);
        step();
        check("bad_result", 64'(bus.result), 64'd0);
        check("bad_err", 64'(bus.out_err), 64'd1);
        offer(EXT_SIGN, 16'h7FFF);
        step();
        check("after_bad", 64'(bus.result), 64'h0000_7FFF);
        check("after_bad_err", 64'(bus.out_err), 64'd0);
        bus.in_valid = 1'b0;
        step();

        // stall: A, B taken, C held off
        bus.out_ready = 1'b0;
        offer(EXT_ZERO, 16'h00AA);
        step();
        check("stall_a_ready", 64'(bus.in_ready), 64'd1);
        check("stall_a", 64'(bus.result), 64'h0000_00AA);
        offer(EXT_ZERO, 16'h00BB);
        step();
        check("skid_ready", 64'(bus.in_ready), 64'd0);
        check("skid_hold_a", 64'(bus.result), 64'h0000_00AA);
        offer(EXT_ZERO, 16'h00CC);
        step();
        step();
        check("c_held_ready", 64'(bus.in_ready), 64'd0);
        check("c_held_a", 64'(bus.result), 64'h0000_00AA);
        bus.out_ready = 1'b1;
        step();
        check("order_b", 64'(bus.result), 64'h0000_00BB);
        check("order_b_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("order_c", 64'(bus.result), 64'h0000_00CC);
        bus.in_valid = 1'b0;
        step();
        check("no_dup", 64'(bus.out_valid), 64'd0);

        // flush from SKID with a live input
        bus.out_ready = 1'b0;
        offer(EXT_ZERO, 16'h0011);
        step();
        offer(EXT_ZERO, 16'h0022);
        step();
        check("pre_flush_skid", 64'(bus.in_ready), 64'd0);
        offer(EXT_ZERO, 16'h0033);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check("flush_dropped", 64'(bus.out_valid), 64'd0);

        // reset while FULL and stalled
        bus.out_ready = 1'b0;
        offer(EXT_SIGN, 16'h8000);
        step();
        check("pre_rst_full", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_result", 64'(bus.result), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        step();

        // 64-bit operand width
        bus64.out_ready = 1'b1;
        bus64.in_valid  = 1'b1;
        bus64.ext_op    = EXT_SIGN;
        bus64.immediate = 16'h8000;
        step();
        check("w64_sign", bus64.result, 64'hFFFF_FFFF_FFFF_8000);
        bus64.ext_op    = EXT_UPPER;
        bus64.immediate = 16'h0001;
        step();
        check("w64_upper", bus64.result, 64'h0001_0000_0000_0000);
        bus64.ext_op    = EXT_BRANCH;
        bus64.immediate = 16'h4000;
        step();
        check("w64_branch", bus64.result, 64'h0000_0000_0001_0000);
        bus64.in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
